// File: rtl/pll_reset_sequencer.sv
// Qualifies an asynchronous PLL lock and releases staged core and video resets.
// Retries from scratch on lock loss or PSRAM init timeout; all outputs registered.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_STABLE  = 1024,
  parameter int VIDEO_DELAY  = 16,
  parameter int INIT_TIMEOUT = 1048575,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       init_done,
  output logic       rst_core,
  output logic       rst_video,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    WAIT_INIT = 3'd3,
    VID_DLY   = 3'd4,
    RUN       = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] VIDEO_LOAD = CNT_W'(VIDEO_DELAY - 1);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       loss_q, loss_d;
  logic             rst_core_q, rst_video_q, ready_q;
  logic             core_released;
  logic             lock_lost;

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  // Lock loss only counts once the core has been let out of reset.
  assign core_released = (state_q == WAIT_INIT) || (state_q == VID_DLY) || (state_q == RUN);
  assign lock_lost     = core_released && !lock_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    loss_d    = loss_q;
    if (lock_lost) begin
      state_d = WAIT_LOCK;
      if (loss_q != 8'hFF) begin
        loss_d = loss_q + 8'd1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = LOCK_LOAD;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == '0) begin
            state_d = WAIT_INIT;
            cnt_d   = INIT_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        WAIT_INIT: begin
          if (init_done) begin
            state_d = VID_DLY;
            cnt_d   = VIDEO_LOAD;
          end else if (cnt_q == '0) begin
            state_d   = WAIT_LOCK;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        VID_DLY: begin
          if (!init_done) begin
            state_d = WAIT_INIT;
            cnt_d   = INIT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RUN: begin
          if (!init_done) begin
            state_d = WAIT_INIT;
            cnt_d   = INIT_LOAD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      loss_q      <= 8'd0;
      rst_core_q  <= 1'b1;
      rst_video_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      loss_q      <= loss_d;
      rst_core_q  <= !((state_d == WAIT_INIT) || (state_d == VID_DLY) || (state_d == RUN));
      rst_video_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
    end
  end

  assign rst_core      = rst_core_q;
  assign rst_video     = rst_video_q;
  assign ready         = ready_q;
  assign timeout_err   = timeout_q;
  assign lock_loss_cnt = loss_q;
  assign state_o       = state_q;

endmodule
